// File: rtl/lfsr_counter.sv
// Fibonacci LFSR counter with clear-to-seed, terminal-state decode and all-zero lockup recovery.
// Optional step index output is enabled by defining LFSR_COUNTER_STEP_IDX_EN.
module lfsr_counter #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  // Default is the predecessor of the default seed (top bit only).
  parameter logic [WIDTH-1:0] TC_VALUE = WIDTH'(1) << (WIDTH - 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [WIDTH-1:0] lfsr_out,
  output logic             tc,
  output logic             lockup
`ifdef LFSR_COUNTER_STEP_IDX_EN
  ,
  output logic [WIDTH-1:0] step_idx
`endif
);

  // Maximal-length tap masks; bit (t-1) set for each 1-indexed tap t.
  function automatic logic [15:0] tap_mask(input int unsigned w);
    case (w)
      3:       return 16'h0006;
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h0000;
    endcase
  endfunction

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(tap_mask(WIDTH));

  if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
    $error("lfsr_counter: WIDTH must be in 3..16");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_counter: SEED must be nonzero");
  end

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic             lockup_q, lockup_d;

  // Clear beats lockup repair, which beats normal advance.
  always_comb begin
    lfsr_d   = {lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)};
    lockup_d = 1'b0;
    if (clr) begin
      lfsr_d = SEED;
    end else if (lfsr_q == '0) begin
      lfsr_d   = SEED;
      lockup_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q   <= SEED;
      lockup_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      lockup_q <= lockup_d;
    end
  end

  assign lfsr_out = lfsr_q;
  assign tc       = (lfsr_q == TC_VALUE);
  assign lockup   = lockup_q;

`ifdef LFSR_COUNTER_STEP_IDX_EN
  localparam logic [WIDTH-1:0] STEP_LAST = WIDTH'((32'd1 << WIDTH) - 32'd2);

  logic [WIDTH-1:0] step_q, step_d;

  // Wraps at period end, in step with the state returning to SEED.
  always_comb begin
    step_d = (step_q == STEP_LAST) ? '0 : step_q + WIDTH'(1);
    if (clr || lfsr_q == '0) begin
      step_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      step_q <= '0;
    end else begin
      step_q <= step_d;
    end
  end

  assign step_idx = step_q;
`endif

endmodule

// File: tb/tb_lfsr_counter.sv
// Scoreboard bench for lfsr_counter (WIDTH=4): a sequence-table model predicts each sample,
// a separate monitor compares the DUT after every clock edge and after each reset assertion.
module tb_lfsr_counter;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [3:0] lfsr_out;
  logic       tc;
  logic       lockup;
`ifdef LFSR_COUNTER_STEP_IDX_EN
  logic [3:0] step_idx;
`endif

  lfsr_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr),
    .lfsr_out (lfsr_out),
    .tc       (tc),
    .lockup   (lockup)
`ifdef LFSR_COUNTER_STEP_IDX_EN
    ,
    .step_idx (step_idx)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] lfsr;
    logic       tc;
    logic       lk;
    logic [3:0] step;
  } exp_t;

  exp_t exp_q[$];

  logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                           4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                           4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

  int n_cmp = 0;
  int n_err = 0;

  // Model: position in the published sequence plus a lockup flag.
  int   idx  = 0;
  logic lk_m = 1'b0;

  task automatic push_exp();
    exp_t e;
    e.lfsr = seq[idx];
    e.tc   = (seq[idx] == 4'b1000);
    e.lk   = lk_m;
    e.step = 4'(idx);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  // One clock cycle of stimulus; z plants an all-zero state before the edge.
  task automatic cycle(input logic r, input logic c, input logic z);
    logic zero_m;
    @(negedge clk);
    if (!r && reset) begin
      idx  = 0;
      lk_m = 1'b0;
      push_exp();
    end
    zero_m = 1'b0;
    reset  = r;
    clr    = c;
    if (z && r) begin
      force dut.lfsr_q = 4'b0000;
      #1;
      release dut.lfsr_q;
      zero_m = 1'b1;
    end
    if (!r || c) begin
      idx  = 0;
      lk_m = 1'b0;
    end else if (zero_m) begin
      idx  = 0;
      lk_m = 1'b1;
    end else begin
      idx  = (idx + 1) % 15;
      lk_m = 1'b0;
    end
    push_exp();
  endtask

  // Monitor: one expected entry per clock edge and per reset assertion.
  always begin
    exp_t e;
    @(posedge clk or negedge reset);
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("lfsr_out", 32'(lfsr_out), 32'(e.lfsr));
      chk("tc", 32'(tc), 32'(e.tc));
      chk("lockup", 32'(lockup), 32'(e.lk));
`ifdef LFSR_COUNTER_STEP_IDX_EN
      chk("step_idx", 32'(step_idx), 32'(e.step));
`endif
    end
  end

  initial begin
    logic r, c, z;
    reset = 1'b1;
    clr   = 1'b0;

    // Reset held for two edges, then free run through a full period and beyond.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b0);

    // Clear held two edges starting from state 1101.
    for (int i = 0; i < 15 && idx != 6; i++) cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

    // Reset and clear together mid-sequence.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0);

    // All-zero lockup repair.
    cycle(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0);

    // Randomized mix of advance, clear, reset and lockup injection.
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 31) != 0);
      c = ($urandom_range(0, 7) == 0);
      z = ($urandom_range(0, 39) == 0);
      cycle(r, c, z);
    end
    cycle(1'b1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected samples never compared", exp_q.size());
    end
    if (n_cmp < 12) begin
      n_err++;
      $display("FAIL count: only %0d comparisons made", n_cmp);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lfsr_counter.md
Name: lfsr_counter

Overview:
Free-running Fibonacci LFSR pseudo-random counter with a parameterised width and a maximal-length tap table. It also provides a synchronous clear-to-seed, a terminal-state decode and all-zero lockup recovery. It sits as a leaf block used for pseudo-random sequencing and cheap long-period counting/timeouts.

Parameters:
- WIDTH, 4, LFSR register width; legal range 3..16.
- SEED, 1 (WIDTH'b0…01), state loaded on reset/clr; must be nonzero (elaboration error if 0).
- TC_VALUE, 4'b1000 (for WIDTH=4), state decoded on tc; default is the state that precedes SEED in the sequence.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear to SEED, active-high.
- lfsr_out  output  WIDTH  current LFSR state, driven directly from the register.
- tc  output  1  high while lfsr_out == TC_VALUE (combinational decode of the register).
- lockup  output  1  high for one cycle after an all-zero state was detected and repaired.

Behaviour:
- reset low: lfsr_out=SEED, tc=(SEED==TC_VALUE), lockup=0, immediately and independent of clk.
- Priority at each rising edge: reset (async) > clr > lockup repair > normal advance.
- clr=1 at an edge: lfsr_out<=SEED; no advance that cycle; lockup<=0.
- Normal advance every edge (no enable): lfsr_out <= {q[WIDTH-2:0], fb}, where fb = XOR of the tap bits q[t-1].
- Tap table (1-indexed):
  - 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4
  - 9:9,5; 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1
  - 14:14,5,3,1; 15:15,14; 16:16,15,13,4
- Period is 2^WIDTH-1; the all-zero state is never produced by advance.
- WIDTH=4 sequence from 0001: 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, then back to 0001.
- Lockup: if q==0 at an edge and clr=0, then lfsr_out<=SEED and lockup<=1 for that one cycle; otherwise lockup<=0.
- Reset or clr held for several cycles: lfsr_out stays at SEED. The first advance happens on the first edge after release.
- Reset asserted mid-sequence: immediate return to SEED; no partial update.
- tc has zero latency relative to lfsr_out. With defaults it pulses one cycle in every 15.

Optional Feature:
- Macro: LFSR_COUNTER_STEP_IDX_EN.
- Defined: adds output step_idx [WIDTH-1:0], a binary index of the current state relative to SEED.
  - 0 at reset, clr or lockup repair; otherwise increments each advance.
  - Wraps from 2^WIDTH-2 to 0 on the same edge that lfsr_out returns to SEED.
- Not defined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Hold reset=0 for 2 cycles, then release, clr=0 -> lfsr_out=0001 during reset. After release, successive edges give 0010,0100,1001,0011; lockup=0 throughout.
- Run 15 edges from 0001 -> exact 15-state sequence above with no repeats. Cycle 16 returns 0001; tc=1 only while lfsr_out=1000.
- With lfsr_out=1101, assert clr for 2 edges -> lfsr_out=0001 after the first edge and stays 0001. The first edge after clr drops gives 0010.
- Assert reset and clr together mid-sequence, then release both -> lfsr_out=0001 asynchronously. The sequence restarts 0010 on the next edge.
- Force the register to 0000 (backdoor) -> next edge gives lfsr_out=0001 and lockup=1 for one cycle, then lockup=0 and the normal sequence resumes.
- With the macro defined, run 20 edges from reset -> step_idx goes 0..14, wraps to 0 exactly when lfsr_out=0001, then continues 1..4.
